// File: rtl/fifo_rx_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rx_pkg
// Shared definitions for the credit-managed receive FIFO:
//   - default geometry (character width, address width)
//   - default flow-control constants (characters per FCT, credit ceiling)
//   - encoding of the FCT request control FSM
// Imported by fifo_rx_credit_if, fct_credit_ctrl and fifo_rx_credit.
// -----------------------------------------------------------------------------
package fifo_rx_pkg;

  localparam int DEF_DWIDTH     = 9;   // 8 data bits + control flag
  localparam int DEF_AWIDTH     = 6;   // depth = 2**AWIDTH
  localparam int DEF_FCT_CHUNK  = 8;   // characters granted by one FCT
  localparam int DEF_MAX_CREDIT = 56;  // ceiling on outstanding credit

  // IDLE: no request, evaluating whether another FCT fits.
  // REQ : fct_req asserted, waiting for fct_ack.
  // GAP : one cycle after an ack so back-to-back grants cannot happen.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } fct_state_e;

endpackage

// File: rtl/fifo_rx_credit_if.sv
// -----------------------------------------------------------------------------
// fifo_rx_credit_if
// Bundles the data path and flow-control signals of fifo_rx_credit.
//   master : the environment (writes characters, reads them, acknowledges FCTs)
//   slave  : the FIFO itself
// Signals:
//   wr_en / data_in          character write strobe and data
//   rd_en                    read request
//   data_out / rd_valid      registered read data and its one-cycle valid pulse
//   f_full / f_empty         occupancy flags
//   counter                  occupancy, 0..2**AWIDTH
//   credit                   characters the link partner may still send
//   fct_req / fct_ack        FCT transmit request (level) and sent pulse
//   overflow_credit_error    sticky credit violation
//   almost_full              only when FIFO_RX_ALMOST_FULL_EN is defined
// -----------------------------------------------------------------------------
interface fifo_rx_credit_if
  import fifo_rx_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
);

  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic [DWIDTH-1:0] data_out;
  logic              rd_valid;
  logic              f_full;
  logic              f_empty;
  logic [AWIDTH:0]   counter;
  logic [AWIDTH:0]   credit;
  logic              fct_req;
  logic              fct_ack;
  logic              overflow_credit_error;
`ifdef FIFO_RX_ALMOST_FULL_EN
  logic              almost_full;
`endif

  modport master (
    output wr_en, data_in, rd_en, fct_ack,
    input  data_out, rd_valid, f_full, f_empty, counter, credit, fct_req,
`ifdef FIFO_RX_ALMOST_FULL_EN
    input  almost_full,
`endif
    input  overflow_credit_error
  );

  modport slave (
    input  wr_en, data_in, rd_en, fct_ack,
    output data_out, rd_valid, f_full, f_empty, counter, credit, fct_req,
`ifdef FIFO_RX_ALMOST_FULL_EN
    output almost_full,
`endif
    output overflow_credit_error
  );

endinterface

// File: rtl/fct_credit_ctrl.sv
// -----------------------------------------------------------------------------
// fct_credit_ctrl
// Credit accounting and FCT request FSM for the receive FIFO.
// Credit is the number of characters the link partner may still send. Each
// accepted write consumes one; each acknowledged FCT grants FCT_CHUNK. An FCT
// is requested only when the granted characters are guaranteed to fit in FIFO
// space not already promised (uncommitted = depth - counter - credit) and the
// credit ceiling MAX_CREDIT would not be exceeded.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   wr_acc        a write is being accepted this cycle (credit > 0 guaranteed)
//   fct_ack       FCT-sent pulse; ignored unless fct_req is high
//   counter       current FIFO occupancy
//   credit        outstanding credit (registered)
//   fct_req       FCT transmit request (registered FSM output)
// -----------------------------------------------------------------------------
module fct_credit_ctrl
  import fifo_rx_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int FCT_CHUNK  = DEF_FCT_CHUNK,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_acc,
  input  logic            fct_ack,
  input  logic [AWIDTH:0] counter,
  output logic [AWIDTH:0] credit,
  output logic            fct_req
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef logic [AWIDTH:0]   cnt_t;
  // One extra bit so depth - counter - credit and credit + FCT_CHUNK never wrap.
  typedef logic [AWIDTH+1:0] wide_t;

  fct_state_e state_q, state_d;
  logic       fct_req_q, fct_req_d;
  cnt_t       credit_q, credit_d;

  wide_t      space;
  wide_t      credit_plus;
  logic       grant_ok;
  logic       ack_acc;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    space       = wide_t'(DEPTH) - wide_t'(counter) - wide_t'(credit_q);
    credit_plus = wide_t'(credit_q) + wide_t'(FCT_CHUNK);
    grant_ok    = (space >= wide_t'(FCT_CHUNK)) &&
                  (credit_plus <= wide_t'(MAX_CREDIT));
    ack_acc     = fct_ack && fct_req_q;

    // Write and ack in the same cycle fold into one update: +FCT_CHUNK-1.
    credit_d = credit_q;
    if (ack_acc) credit_d = credit_d + cnt_t'(FCT_CHUNK);
    if (wr_acc)  credit_d = credit_d - cnt_t'(1);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_ok) state_d = ST_REQ;
      ST_REQ:  if (fct_ack)  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered request: high exactly while the FSM sits in REQ.
    fct_req_d = (state_d == ST_REQ);
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fct_req_q <= 1'b0;
      credit_q  <= '0;
    end else begin
      state_q   <= state_d;
      fct_req_q <= fct_req_d;
      credit_q  <= credit_d;
    end
  end

  assign credit  = credit_q;
  assign fct_req = fct_req_q;

endmodule

// File: rtl/fifo_rx_credit.sv
// -----------------------------------------------------------------------------
// fifo_rx_credit
// Receive FIFO with credit-based flow control. Characters arrive on wr_en and
// are only accepted while the link partner holds credit; a character sent
// without credit (or into a full FIFO) is dropped and latches the sticky
// overflow_credit_error flag. Reads return registered data one cycle after
// rd_en with a single-cycle rd_valid. Credit accounting and FCT requests live
// in fct_credit_ctrl.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   bus           fifo_rx_credit_if.slave (see interface header)
// Parameters: DWIDTH, AWIDTH, FCT_CHUNK, MAX_CREDIT (FCT_CHUNK..2**AWIDTH),
//   AF_LEVEL (only with FIFO_RX_ALMOST_FULL_EN).
// Optional feature: define FIFO_RX_ALMOST_FULL_EN to add the AF_LEVEL
// parameter and the almost_full output (counter >= AF_LEVEL).
// -----------------------------------------------------------------------------
module fifo_rx_credit
  import fifo_rx_pkg::*;
#(
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int FCT_CHUNK  = DEF_FCT_CHUNK,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
`ifdef FIFO_RX_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL   = (1 << AWIDTH) - FCT_CHUNK
`endif
) (
  input  logic            clock,
  input  logic            reset,
  fifo_rx_credit_if.slave bus
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef logic [AWIDTH:0]   cnt_t;
  typedef logic [AWIDTH-1:0] ptr_t;
  typedef logic [DWIDTH-1:0] data_t;

  data_t mem [DEPTH];

  ptr_t  wr_ptr_q,   wr_ptr_d;
  ptr_t  rd_ptr_q,   rd_ptr_d;
  cnt_t  counter_q,  counter_d;
  data_t data_out_q, data_out_d;
  logic  rd_valid_q, rd_valid_d;
  logic  err_q,      err_d;

  logic  f_full, f_empty;
  logic  wr_acc, rd_acc;
  cnt_t  credit;
  logic  fct_req;

  assign f_full  = (counter_q == cnt_t'(DEPTH));
  assign f_empty = (counter_q == '0);

  // Credit is the primary gate; f_full is a backstop for a misbehaving partner.
  assign wr_acc  = bus.wr_en && (credit != '0) && !f_full;
  assign rd_acc  = bus.rd_en && !f_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    counter_d  = counter_q;
    data_out_d = data_out_q;
    rd_valid_d = rd_acc;
    err_d      = err_q | (bus.wr_en && !wr_acc);

    // Pointers wrap naturally at 2**AWIDTH.
    if (wr_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ptr_t'(1);
      data_out_d = mem[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   counter_d = counter_q + cnt_t'(1);
      2'b01:   counter_d = counter_q - cnt_t'(1);
      default: counter_d = counter_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      counter_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      counter_q  <= counter_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the storage array has no reset; stale contents are unreachable once
  // the pointers and counter are cleared, and a resettable array would not map
  // onto RAM.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) mem[wr_ptr_q] <= bus.data_in;
  end

  fct_credit_ctrl #(
    .AWIDTH     (AWIDTH),
    .FCT_CHUNK  (FCT_CHUNK),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_fct_credit_ctrl (
    .clock   (clock),
    .reset   (reset),
    .wr_acc  (wr_acc),
    .fct_ack (bus.fct_ack),
    .counter (counter_q),
    .credit  (credit),
    .fct_req (fct_req)
  );

  assign bus.data_out              = data_out_q;
  assign bus.rd_valid              = rd_valid_q;
  assign bus.f_full                = f_full;
  assign bus.f_empty               = f_empty;
  assign bus.counter               = counter_q;
  assign bus.credit                = credit;
  assign bus.fct_req               = fct_req;
  assign bus.overflow_credit_error = err_q;

`ifdef FIFO_RX_ALMOST_FULL_EN
  assign bus.almost_full = (counter_q >= cnt_t'(AF_LEVEL));
`endif

endmodule

// File: tb/tb_fifo_rx_credit.sv
// -----------------------------------------------------------------------------
// tb_fifo_rx_credit
// Scoreboard bench for fifo_rx_credit. The driver applies one cycle of stimulus
// at each falling edge, advances a behavioural model (a character queue plus
// integer credit and a small request/cooldown description of FCT handshaking)
// and pushes the expected post-edge status into a queue; expected read data is
// pushed when a read is issued. A monitor samples 1 ns after every rising edge
// and compares DUT outputs against those queues.
// -----------------------------------------------------------------------------
module tb_fifo_rx_credit;

  localparam int DW    = 9;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int CHUNK = 8;
  localparam int MAXC  = 56;

  typedef struct {
    bit rst;
    int counter;
    int credit;
    bit full;
    bit empty;
    bit req;
    bit err;
    bit rv;
    bit af;
  } status_t;

  logic clk;
  logic reset;

  fifo_rx_credit_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  fifo_rx_credit #(
    .DWIDTH     (DW),
    .AWIDTH     (AW),
    .FCT_CHUNK  (CHUNK),
    .MAX_CREDIT (MAXC)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [DW-1:0] m_fifo[$];
  int            m_credit = 0;
  bit            m_req    = 0;
  bit            m_cool   = 0;  // one no-request cycle after an acknowledged FCT
  bit            m_err    = 0;

  status_t       exp_q[$];
  logic [DW-1:0] exp_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the matching model update.
  task automatic step(input bit rst, input bit wr, input bit rd, input bit ack);
    status_t       e;
    bit            wr_ok, rd_ok, ack_ok, want;
    int            space;
    logic [DW-1:0] din;
    din = DW'($urandom);
    @(negedge clk);
    reset       = rst;
    bus.wr_en   = wr;
    bus.data_in = din;
    bus.rd_en   = rd;
    bus.fct_ack = ack;
    e.rv = 1'b0;
    if (rst) begin
      m_fifo.delete();
      m_credit = 0;
      m_req    = 0;
      m_cool   = 0;
      m_err    = 0;
    end else begin
      wr_ok  = wr && (m_credit > 0) && (m_fifo.size() < DEPTH);
      rd_ok  = rd && (m_fifo.size() > 0);
      ack_ok = ack && m_req;
      space  = DEPTH - m_fifo.size() - m_credit;
      want   = (space >= CHUNK) && (m_credit + CHUNK <= MAXC);
      if (rd_ok) exp_data.push_back(m_fifo.pop_front());
      if (wr_ok) m_fifo.push_back(din);
      if (wr && !wr_ok) m_err = 1;
      if (ack_ok) m_credit += CHUNK;
      if (wr_ok)  m_credit -= 1;
      if (m_req) begin
        if (ack) begin
          m_req  = 0;
          m_cool = 1;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else begin
        m_req = want;
      end
      e.rv = rd_ok;
    end
    e.rst     = rst;
    e.counter = m_fifo.size();
    e.credit  = m_credit;
    e.full    = (m_fifo.size() == DEPTH);
    e.empty   = (m_fifo.size() == 0);
    e.req     = m_req;
    e.err     = m_err;
    e.af      = (m_fifo.size() >= DEPTH - CHUNK);
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle that has a pending expectation.
  initial begin
    status_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("counter",  32'(bus.counter),               32'(e.counter));
        check("credit",   32'(bus.credit),                32'(e.credit));
        check("f_full",   32'(bus.f_full),                32'(e.full));
        check("f_empty",  32'(bus.f_empty),               32'(e.empty));
        check("fct_req",  32'(bus.fct_req),               32'(e.req));
        check("ovf_err",  32'(bus.overflow_credit_error), 32'(e.err));
        check("rd_valid", 32'(bus.rd_valid),              32'(e.rv));
`ifdef FIFO_RX_ALMOST_FULL_EN
        check("almost_full", 32'(bus.almost_full), 32'(e.af));
`endif
        if (e.rst) check("data_out_reset", 32'(bus.data_out), 32'd0);
      end
      if (bus.rd_valid === 1'b1) begin
        if (exp_data.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_data: rd_valid=1 with no read outstanding (t=%0t)", $time);
        end else begin
          check("data_out", 32'(bus.data_out), 32'(exp_data.pop_front()));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    bus.fct_ack = 1'b0;

    step(1, 0, 0, 0);

    // Credit ramps 8..56 with prompt acks, then no further request.
    for (int i = 0; i < 60; i++) step(0, 0, 0, m_req);

    // 56 writes consume all credit; the 57th is dropped and flags an error.
    for (int i = 0; i < 57; i++) step(0, 1, 0, 0);

    // Read 8 to open space, then acknowledge the next FCT.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      if (m_req) begin
        step(0, 0, 0, 1);
        break;
      end
      step(0, 0, 0, 0);
    end

    // Bring credit to 5, then write and ack in the same cycle.
    for (int i = 0; i < 40; i++) begin
      if (m_credit > 5) step(0, 1, 0, 0);
      else if (m_credit == 5 && m_req) begin
        step(0, 1, 0, 1);
        break;
      end else step(0, 0, 0, 0);
    end

    // Randomised traffic: write-heavy then read-heavy, spurious acks included.
    step(1, 0, 0, 0);
    for (int i = 0; i < 1600; i++) begin
      bit wr, rd, ack;
      wr  = ($urandom_range(0, 9) < 7);
      rd  = (i < 800) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 7);
      ack = m_req ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
      step(0, wr, rd, ack);
    end

    // Reach counter 30 with fct_req high, then reset with activity in flight.
    step(1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      if (m_fifo.size() < 30)
        step(0, m_credit > 0, 0, m_req && (m_fifo.size() + m_credit < 30));
      else if (!m_req) step(0, 0, 0, 0);
      else break;
    end
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);   // ack with no request outstanding is ignored
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0 || exp_data.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d status and %0d data expectations left, required 0",
               exp_q.size(), exp_data.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rx_credit.md
FIFO_RX_CREDIT -- requirements
Module: fifo_rx_credit

Interface
REQ-001 SHALL have parameter DWIDTH, default 9, meaning character width (8 data bits + control flag).
REQ-002 SHALL have parameter AWIDTH, default 6, meaning address width; depth = 2**AWIDTH.
REQ-003 SHALL have parameter FCT_CHUNK, default 8, meaning characters granted per FCT.
REQ-004 SHALL have parameter MAX_CREDIT, default 56, meaning ceiling on outstanding credit; legal range FCT_CHUNK..2**AWIDTH.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  rising-edge clock, sole clock domain.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 wr_en  input  1  single-cycle write strobe, one character per asserted cycle.
REQ-009 data_in  input  DWIDTH  character to store.
REQ-010 rd_en  input  1  read request.
REQ-011 data_out  output  DWIDTH  registered read data.
REQ-012 rd_valid  output  1  data_out valid, one-cycle pulse.
REQ-013 f_full / f_empty  output  1 each  occupancy flags.
REQ-014 counter  output  AWIDTH+1  occupancy, 0..2**AWIDTH.
REQ-015 credit  output  AWIDTH+1  characters the link partner may still send.
REQ-016 fct_req  output  1  level request to transmit one FCT.
REQ-017 fct_ack  input  1  one-cycle pulse: FCT sent.
REQ-018 overflow_credit_error  output  1  sticky credit violation.

Function
REQ-019 Write with wr_en=1 and credit>0 and !f_full SHALL store data_in at wr_ptr, increment wr_ptr (wrap at 2**AWIDTH), decrement credit.
REQ-020 Write with credit==0 or f_full SHALL be discarded and set overflow_credit_error next cycle; pointers, counter unchanged.
REQ-021 Read with rd_en=1 and !f_empty SHALL present mem[rd_ptr] on data_out with rd_valid=1 one cycle later, increment rd_ptr; rd_en on empty SHALL be ignored, rd_valid=0.
REQ-022 counter SHALL change by +1 (write only), -1 (read only), 0 (both accepted or neither); f_full = (counter==2**AWIDTH), f_empty = (counter==0), combinational from counter.
REQ-023 Uncommitted space = 2**AWIDTH - counter - credit; fct_req SHALL assert when uncommitted space >= FCT_CHUNK and credit+FCT_CHUNK <= MAX_CREDIT.
REQ-024 fct_req SHALL hold until fct_ack; fct_ack with fct_req=1 SHALL add FCT_CHUNK to credit; fct_ack with fct_req=0 SHALL be ignored.
REQ-025 Simultaneous accepted write and fct_ack SHALL yield credit + FCT_CHUNK - 1 in one update.
REQ-026 fct_req SHALL deassert the cycle after fct_ack and re-evaluate REQ-023 on the following cycle (no back-to-back grants without a gap cycle).
REQ-027 credit SHALL never exceed MAX_CREDIT nor underflow below 0.
REQ-028 Control FSM SHALL have states IDLE (no request), REQ (fct_req=1), GAP (one cycle post-ack); IDLE->REQ on REQ-023, REQ->GAP on fct_ack, GAP->IDLE unconditionally.

Reset
REQ-029 reset=1 at a clock edge SHALL clear wr_ptr, rd_ptr, counter, credit, data_out, rd_valid, fct_req, overflow_credit_error, FSM to IDLE; f_empty=1, f_full=0.
REQ-030 Reset mid-operation SHALL discard in-flight write/read and pending fct_ack; memory contents need not be cleared.

Configuration
REQ-031 With FIFO_RX_ALMOST_FULL_EN defined, SHALL add parameter AF_LEVEL (default 2**AWIDTH-FCT_CHUNK) and output almost_full = (counter >= AF_LEVEL); without it, port and logic SHALL be absent.

Structure
REQ-032 Shared package fifo_rx_pkg SHALL hold FSM state encoding and default FCT_CHUNK/MAX_CREDIT constants.
REQ-033 Credit accounting and FSM SHALL be sub-module fct_credit_ctrl; storage and pointers stay in fifo_rx_credit.

Verification
REQ-034 Reset, no traffic, fct_ack on each fct_req -> credit steps 8,16,...,56 then fct_req stays 0.
REQ-035 Credit 56, write 56 chars, no reads -> counter=56, credit=0; 57th write -> overflow_credit_error=1, counter stays 56.
REQ-036 Counter 56, read 8 -> fct_req rises; fct_ack -> credit=8.
REQ-037 Write and fct_ack same cycle at credit=5 -> credit=12.
REQ-038 Fill/drain 3*2**AWIDTH characters with interleaved reads -> data_out matches write order across pointer wrap, rd_valid one cycle after rd_en.
REQ-039 Assert reset with counter=30, fct_req=1 -> next cycle all outputs at reset values, fct_ack that cycle has no effect.
